lsu_mem_initiator: RTL
======================

// Module: lsu_mem_initiator
// PURPOSE
//  Multi-cycle load/store initiator. It sits between the datapath (ALUResult as
//  address, RD2 as store data) and a handshaked data memory. It drives byte/half/
//  word requests, waits for the response, then returns aligned and extended load
//  data. Stall holds the datapath while an access is outstanding.
// PARAMETERS
//  A_WIDTH  32   byte address width
//  D_WIDTH  32   data width; fixed at 32, 4 byte lanes
//  TIMEOUT  255  max WAIT cycles before Err; range 1..255, 8-bit counter
// PORTS
//  CLK            in   1        clock, rising edge
//  RST            in   1        synchronous reset, active-high
//  Start          in   1        access request from datapath; level, held while Stall
//  MemWrite       in   1        1=store, 0=load; sampled with Start
//  Funct3         in   3        000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
//  Addr           in   A_WIDTH  byte address
//  WriteData      in   D_WIDTH  store data, LSBs used for B/H
//  Stall          out  1        = Start & ~Done (combinational)
//  Done           out  1        1-cycle pulse: access finished
//  ReadData       out  D_WIDTH  extended load data; valid when Done; held otherwise
//  Misaligned     out  1        with Done: misaligned or illegal access, nothing issued
//  Err            out  1        with Done: response timeout
//  mem_req_valid  out  1        request valid
//  mem_req_ready  in   1        request accepted when valid&ready
//  mem_req_we     out  1        write enable
//  mem_req_addr   out  A_WIDTH  word address {Addr[A_WIDTH-1:2],2'b00}
//  mem_req_wdata  out  D_WIDTH  store data replicated across lanes
//  mem_req_wstrb  out  4        byte strobes; 4'b0000 for loads
//  mem_rsp_valid  in   1        1-cycle response, loads and stores alike
//  mem_rsp_rdata  in   D_WIDTH  raw word, valid with mem_rsp_valid
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, ReadData=0, timeout counter=0.
//  FSM:
//   IDLE: on Start, latch MemWrite/Funct3/Addr/WriteData.
//     If legal and aligned, go to REQ. Otherwise go to DONE with Misaligned=1.
//   REQ: mem_req_valid=1, with request fields stable from latched values.
//     On ready, go to WAIT and clear the counter.
//   WAIT: mem_rsp_valid is sampled only here.
//     On rsp_valid, capture data and go to DONE.
//     Otherwise the counter increments; reaching TIMEOUT goes to DONE with Err=1.
//   DONE: Done=1 for one cycle, then return to IDLE.
//     Start seen in this cycle is not a new access. The datapath drops or advances it.
//  Alignment: H requires Addr[0]=0; W requires Addr[1:0]=0.
//   Illegal Funct3 (011, 11x) sets Misaligned. Store with BU/HU also sets Misaligned.
//  Strobes: B gives 4'b0001<<Addr[1:0]; H gives 4'b0011<<{Addr[1],1'b0}; W gives 4'b1111.
//   wdata for B is {4{wd[7:0]}}, for H is {2{wd[15:0]}}, for W is wd.
//  Loads: select lane from rdata by Addr[1:0].
//   B/H sign-extend; BU/HU zero-extend; W passes the word.
//   Stores leave ReadData unchanged.
//  Latency: Start at cycle 0, req_valid at cycle 1. With ready at cycle 1 and rsp at
//   cycle 2, Done is at cycle 3. Misaligned Done is at cycle 1.
//  Edge cases:
//   - rsp_valid in IDLE/REQ/DONE is ignored.
//   - ready is ignored when valid=0.
//   - Start changes while busy are ignored; latched values are used.
//   - RST mid-access aborts to IDLE next edge; req_valid drops and no Done is issued.
//   - rsp_valid in the same cycle the counter reaches TIMEOUT: the response wins, Err=0.
// TESTING
//  1 LW 0x10, ready immediate, rsp 0xDEADBEEF at next cycle
//    -> req_addr 0x10, wstrb 0000, Done cycle 3, ReadData 0xDEADBEEF.
//  2 LB 0x13, rdata 0x80112233 -> ReadData 0xFFFFFF80.
//    LBU same -> 0x00000080. LHU 0x12 -> 0x00008011.
//  3 SB 0x05, wd 0x000000AB -> addr 0x04, wstrb 0010, wdata 0xABABABAB.
//    SH 0x06, wd 0x1234 -> wstrb 1100, wdata 0x12341234.
//  4 LW 0x02, or SH 0x01, or Funct3=011 -> no req_valid, Done+Misaligned at cycle 1.
//  5 ready low for 3 cycles -> req_valid and fields stable; TIMEOUT=4 with no rsp -> Done+Err.
//  6 RST during WAIT, then stray rsp_valid -> IDLE, no Done. Next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Handshaked data-memory port used by the load/store initiator.
// Split request/response: one request beat per access, one response beat back.
interface lsu_mem_if #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned D_WIDTH = 32
);
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic               mem_req_we;
    logic [A_WIDTH-1:0] mem_req_addr;
    logic [D_WIDTH-1:0] mem_req_wdata;
    logic [3:0]         mem_req_wstrb;
    logic               mem_rsp_valid;
    logic [D_WIDTH-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Multi-cycle load/store initiator: issues one byte/half/word memory request per access,
// waits for the response (with timeout) and returns lane-selected, extended load data.
module lsu_mem_initiator #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start,
    input  logic               MemWrite,
    input  logic [2:0]         Funct3,
    input  logic [A_WIDTH-1:0] Addr,
    input  logic [D_WIDTH-1:0] WriteData,
    output logic               Stall,
    output logic               Done,
    output logic [D_WIDTH-1:0] ReadData,
    output logic               Misaligned,
    output logic               Err,
    lsu_mem_if.master          mem
);
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] wd_q, wd_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               mis_q, mis_d;
    logic               err_q, err_d;

    logic               req_ok;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [D_WIDTH-1:0] load_val;
    logic [3:0]         strb;
    logic [D_WIDTH-1:0] wdata;

    // Legality and alignment of the access presented at Start.
    always_comb begin
        req_ok = 1'b0;
        case (Funct3)
            3'b000:  req_ok = 1'b1;
            3'b001:  req_ok = ~Addr[0];
            3'b010:  req_ok = (Addr[1:0] == 2'b00);
            3'b100:  req_ok = ~MemWrite;
            3'b101:  req_ok = ~MemWrite & ~Addr[0];
            default: req_ok = 1'b0;
        endcase
    end

    always_comb begin
        lane_b = mem.mem_rsp_rdata[7:0];
        case (addr_q[1:0])
            2'd0:    lane_b = mem.mem_rsp_rdata[7:0];
            2'd1:    lane_b = mem.mem_rsp_rdata[15:8];
            2'd2:    lane_b = mem.mem_rsp_rdata[23:16];
            default: lane_b = mem.mem_rsp_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? mem.mem_rsp_rdata[31:16] : mem.mem_rsp_rdata[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'b0, lane_b};
            3'b101:  load_val = {16'b0, lane_h};
            default: load_val = mem.mem_rsp_rdata;
        endcase
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                strb  = 4'b0001 << addr_q[1:0];
                wdata = {4{wd_q[7:0]}};
            end
            2'b01: begin
                strb  = 4'b0011 << {addr_q[1], 1'b0};
                wdata = {2{wd_q[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = wd_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    we_d    = MemWrite;
                    f3_d    = Funct3;
                    addr_d  = Addr;
                    wd_d    = WriteData;
                    mis_d   = ~req_ok;
                    err_d   = 1'b0;
                    state_d = req_ok ? StReq : StDone;
                end
            end
            StReq: begin
                if (mem.mem_req_ready) begin
                    cnt_d   = 8'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A response arriving on the timeout cycle still counts.
                if (mem.mem_rsp_valid) begin
                    if (!we_q) rdata_d = load_val;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TimeoutCnt) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= 8'd0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign Done              = (state_q == StDone);
    assign Misaligned        = Done & mis_q;
    assign Err               = Done & err_q;
    assign Stall             = Start & ~Done;
    assign ReadData          = rdata_q;
    assign mem.mem_req_valid = (state_q == StReq);
    assign mem.mem_req_we    = we_q;
    assign mem.mem_req_addr  = {addr_q[A_WIDTH-1:2], 2'b00};
    assign mem.mem_req_wdata = wdata;
    assign mem.mem_req_wstrb = we_q ? strb : 4'b0000;
endmodule
